dvfs_governor: RTL

Parametrised DVFS governor, successor to `dvfs_top`. It maps a LOAD_W-bit workload request onto 2**PS_W performance states. It steps one state at a time using safe ordering: voltage is raised before frequency on the way up, and frequency is lowered before voltage on the way down. It enforces a settle interval between the two steps and optionally filters workload jitter with hysteresis. It sits between the workload switches and the clock-divider and regulator VID controls.

---
 rtl/dvfs_pkg.sv | 20 ++
 rtl/dvfs_hyst_filter.sv | 60 ++++++
 rtl/dvfs_governor.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dvfs_pkg.sv
// Shared encodings, defaults and VID mapping for the DVFS governor.
package dvfs_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_V_UP_WAIT = 2'd1;
  localparam logic [1:0] ST_F_DN_WAIT = 2'd2;

  localparam int DVFS_DEF_PS_W          = 2;
  localparam int DVFS_DEF_LOAD_W        = 4;
  localparam int DVFS_DEF_VID_W         = 3;
  localparam int DVFS_DEF_VID_MIN       = 2;
  localparam int DVFS_DEF_SETTLE_CYCLES = 16;
  localparam int DVFS_DEF_HOLD_CYCLES   = 8;

  // Regulator code for a performance state: one VID step per state above VID_MIN.
  function automatic int vid_of(input int vid_min, input int ps);
    return vid_min + ps;
  endfunction

endpackage

// File: rtl/dvfs_hyst_filter.sv
// Registers the workload target; with DVFS_HYST_EN defined it also gates
// eligibility until the target has been stable for HOLD_CYCLES edges.
module dvfs_hyst_filter
  import dvfs_pkg::*;
#(
  parameter int PS_W        = DVFS_DEF_PS_W,
  parameter int HOLD_CYCLES = DVFS_DEF_HOLD_CYCLES
) (
  input  logic            clk,
  input  logic            srst_i,
  input  logic [PS_W-1:0] target_i,
  output logic [PS_W-1:0] target_o,
  output logic            eligible_o
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end

  logic [PS_W-1:0] target_q;

  always_ff @(posedge clk) begin
    if (srst_i) begin
      target_q <= '0;
    end else begin
      target_q <= target_i;
    end
  end

  assign target_o = target_q;

`ifdef DVFS_HYST_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Any change of the registered target restarts the stability window.
  always_comb begin
    hold_d = hold_q;
    if (target_i != target_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_W'(HOLD_CYCLES)) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign eligible_o = (hold_q == HOLD_W'(HOLD_CYCLES));
`else
  assign eligible_o = 1'b1;
`endif

endmodule

// File: rtl/dvfs_governor.sv
// DVFS governor: single-step state changes, voltage-first up, frequency-first down.
// Optional workload hysteresis is enabled by defining DVFS_HYST_EN.
module dvfs_governor
  import dvfs_pkg::*;
#(
  parameter int PS_W          = DVFS_DEF_PS_W,
  parameter int LOAD_W        = DVFS_DEF_LOAD_W,
  parameter int VID_W         = DVFS_DEF_VID_W,
  parameter int VID_MIN       = DVFS_DEF_VID_MIN,
  parameter int SETTLE_CYCLES = DVFS_DEF_SETTLE_CYCLES,
  parameter int HOLD_CYCLES   = DVFS_DEF_HOLD_CYCLES
) (
  input  logic                       clk,
  input  logic                       btnC,
  input  logic [LOAD_W-1:0]          sw,
  output logic [PS_W-1:0]            performance_state,
  output logic [VID_W-1:0]           voltage,
  output logic [PS_W-1:0]            div_sel,
  output logic [(2**PS_W)-1:0]       led,
  output logic                       busy,
  output logic                       step_done
);

  localparam int NUM_STATES = 2 ** PS_W;
  localparam int CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  if (LOAD_W < PS_W) begin : g_bad_load_w
    $error("LOAD_W must be >= PS_W");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (VID_MIN + NUM_STATES - 1 >= 2 ** VID_W) begin : g_bad_vid
    $error("VID_MIN + NUM_STATES - 1 must fit in VID_W bits");
  end

  logic [PS_W-1:0] sw_target;
  logic [PS_W-1:0] target;
  logic            eligible;

  assign sw_target = sw[LOAD_W-1 -: PS_W];

  dvfs_hyst_filter #(
    .PS_W        (PS_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hyst (
    .clk        (clk),
    .srst_i     (btnC),
    .target_i   (sw_target),
    .target_o   (target),
    .eligible_o (eligible)
  );

  logic [1:0]       fsm_q, fsm_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [VID_W-1:0] vid_q, vid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    fsm_d  = fsm_q;
    ps_d   = ps_q;
    vid_d  = vid_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (eligible && (target > ps_q)) begin
          vid_d  = VID_W'(vid_of(VID_MIN, int'(ps_q) + 1));
          cnt_d  = CNT_RELOAD;
          busy_d = 1'b1;
          fsm_d  = ST_V_UP_WAIT;
        end else if (eligible && (target < ps_q)) begin
          ps_d   = ps_q - PS_W'(1);
          cnt_d  = CNT_RELOAD;
          busy_d = 1'b1;
          fsm_d  = ST_F_DN_WAIT;
        end
      end
      ST_V_UP_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ps_d   = ps_q + PS_W'(1);
          done_d = 1'b1;
          busy_d = 1'b0;
          fsm_d  = ST_IDLE;
        end
      end
      ST_F_DN_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Regulator drops only after the slower clock has settled.
          vid_d  = VID_W'(vid_of(VID_MIN, int'(ps_q)));
          done_d = 1'b1;
          busy_d = 1'b0;
          fsm_d  = ST_IDLE;
        end
      end
      default: begin
        fsm_d  = ST_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      fsm_q  <= ST_IDLE;
      ps_q   <= '0;
      vid_q  <= VID_W'(VID_MIN);
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      ps_q   <= ps_d;
      vid_q  <= vid_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign performance_state = ps_q;
  assign voltage           = vid_q;
  assign div_sel           = PS_W'(NUM_STATES - 1) - ps_q;
  assign busy              = busy_q;
  assign step_done         = done_q;

  for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_led
    assign led[gi] = (ps_q == PS_W'(gi));
  end

endmodule
